// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the MEM stage
// and the data-memory responder.
interface data_mem_responder_if #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
);
  logic                     ReqValid_i;
  logic                     ReqReady_o;
  logic                     ReqWrite_i;
  logic [1:0]               ReqSize_i;
  logic                     ReqUnsigned_i;
  logic [ADDRESS_WIDTH-1:0] Addr_i;
  logic [DATA_WIDTH-1:0]    WData_i;
  logic                     RespValid_o;
  logic                     RespReady_i;
  logic [DATA_WIDTH-1:0]    RData_o;
  logic                     RespErr_o;
  logic                     Busy_o;

  modport master (
    output ReqValid_i, ReqWrite_i, ReqSize_i,
    output ReqUnsigned_i, Addr_i, WData_i,
    output RespReady_i,
    input  ReqReady_o, RespValid_o, RData_o,
    input  RespErr_o, Busy_o
  );

  modport slave (
    input  ReqValid_i, ReqWrite_i, ReqSize_i,
    input  ReqUnsigned_i, Addr_i, WData_i,
    input  RespReady_i,
    output ReqReady_o, RespValid_o, RData_o,
    output RespErr_o, Busy_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one serialised load/store at a
// time, little-endian byte/half/word access, fixed access latency.
module data_mem_responder #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_responder_if.slave bus
);

  localparam int DEPTH = 2 ** (ADDRESS_WIDTH - 2);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                     wr_q;
  logic [1:0]               sz_q;
  logic                     uns_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;

  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic accept, exec, we;

  logic                     a_wr;
  logic [1:0]               a_sz;
  logic                     a_uns;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_wdata;

  logic [ADDRESS_WIDTH-3:0] widx;
  logic [1:0]  lane;
  logic [31:0] word, rsh, wlane, ld;
  logic [3:0]  be;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      sz_q    <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.ReqWrite_i;
        sz_q    <= bus.ReqSize_i;
        uns_q   <= bus.ReqUnsigned_i;
        addr_q  <= bus.Addr_i;
        wdata_q <= bus.WData_i;
      end
      if (exec) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    exec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ReqValid_i) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            exec    = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          exec    = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.RespReady_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ReqReady_o  = (state_q == IDLE);
    bus.RespValid_o = (state_q == RESP);
    bus.Busy_o      = (state_q != IDLE);
    bus.RData_o     = (state_q == RESP) ? rdata_q : '0;
    bus.RespErr_o   = (state_q == RESP) & err_q;
  end

  // Zero latency executes on the accept edge, straight off the bus.
  always_comb begin
    if (LATENCY == 0) begin
      a_wr    = bus.ReqWrite_i;
      a_sz    = bus.ReqSize_i;
      a_uns   = bus.ReqUnsigned_i;
      a_addr  = bus.Addr_i;
      a_wdata = bus.WData_i;
    end else begin
      a_wr    = wr_q;
      a_sz    = sz_q;
      a_uns   = uns_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  always_comb begin
    widx  = a_addr[ADDRESS_WIDTH-1:2];
    lane  = a_addr[1:0];
    word  = mem[widx];
    rsh   = word >> {lane, 3'b000};
    err_d = (a_sz == 2'b11)
          | ((a_sz == 2'b01) & a_addr[0])
          | ((a_sz == 2'b10) & (|a_addr[1:0]));
    be    = '0;
    wlane = '0;
    ld    = '0;
    if (!err_d) begin
      unique case (1'b1)
        (a_sz == 2'b00): begin
          be    = 4'b0001 << lane;
          wlane = {4{a_wdata[7:0]}};
          ld    = {{24{~a_uns & rsh[7]}}, rsh[7:0]};
        end
        (a_sz == 2'b01): begin
          be    = a_addr[1] ? 4'b1100 : 4'b0011;
          wlane = {2{a_wdata[15:0]}};
          ld    = {{16{~a_uns & rsh[15]}}, rsh[15:0]};
        end
        default: begin
          be    = 4'b1111;
          wlane = a_wdata;
          ld    = rsh;
        end
      endcase
    end
    rdata_d = (err_d | a_wr) ? '0 : ld;
    we      = exec & rst & a_wr & ~err_d;
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed plan steps plus random
// traffic against a word-array reference model, LATENCY 2 and 0.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) b2 ();
  data_mem_responder_if #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) b0 ();

  data_mem_responder #(
    .ADDRESS_WIDTH(12), .DATA_WIDTH(32), .LATENCY(2)
  ) u_l2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );

  data_mem_responder #(
    .ADDRESS_WIDTH(12), .DATA_WIDTH(32), .LATENCY(0)
  ) u_l0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] mdl [2][1024];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input bit v, input bit w,
                         input logic [1:0] sz, input bit u,
                         input logic [11:0] a, input logic [31:0] wd);
    if (s == 0) begin
      b2.ReqValid_i = v; b2.ReqWrite_i = w; b2.ReqSize_i = sz;
      b2.ReqUnsigned_i = u; b2.Addr_i = a; b2.WData_i = wd;
    end else begin
      b0.ReqValid_i = v; b0.ReqWrite_i = w; b0.ReqSize_i = sz;
      b0.ReqUnsigned_i = u; b0.Addr_i = a; b0.WData_i = wd;
    end
  endtask

  task automatic set_rr(input int s, input bit r);
    if (s == 0) b2.RespReady_i = r;
    else        b0.RespReady_i = r;
  endtask

  function automatic logic rv(input int s);
    return (s == 0) ? b2.RespValid_o : b0.RespValid_o;
  endfunction
  function automatic logic [31:0] rdo(input int s);
    return (s == 0) ? b2.RData_o : b0.RData_o;
  endfunction
  function automatic logic rer(input int s);
    return (s == 0) ? b2.RespErr_o : b0.RespErr_o;
  endfunction
  function automatic logic rqr(input int s);
    return (s == 0) ? b2.ReqReady_o : b0.ReqReady_o;
  endfunction
  function automatic logic bsy(input int s);
    return (s == 0) ? b2.Busy_o : b0.Busy_o;
  endfunction

  // Latency counts cycles after the accept cycle to first RespValid.
  task automatic xact(input int s, input bit w, input logic [1:0] sz,
                      input bit u, input logic [11:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    @(negedge clk);
    set_req(s, 1'b1, w, sz, u, a, wd);
    @(posedge clk);
    #1 set_req(s, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    lat = -1;
    rd  = 'x;
    er  = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rv(s) === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat > 0) begin
      rd = rdo(s);
      er = rer(s);
      set_rr(s, 1'b1);
      @(posedge clk);
      #1 set_rr(s, 1'b0);
    end
  endtask

  task automatic model(input int s, input bit w, input logic [1:0] sz,
                       input bit u, input logic [11:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er);
    int wi, ln;
    logic [31:0] word;
    wi   = int'(a) / 4;
    ln   = int'(a) % 4;
    word = mdl[s][wi];
    rd   = 32'h0;
    er   = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0)
        || (sz == 2'd2 && ln != 0);
    if (!er) begin
      if (w) begin
        case (sz)
          2'd0: word = (word & ~(32'hFF << (8 * ln)))
                     | ((wd & 32'hFF) << (8 * ln));
          2'd1: word = (word & ~(32'hFFFF << (8 * ln)))
                     | ((wd & 32'hFFFF) << (8 * ln));
          default: word = wd;
        endcase
        mdl[s][wi] = word;
      end else begin
        case (sz)
          2'd0: begin
            rd = (word >> (8 * ln)) & 32'hFF;
            if (!u && rd >= 32'h80) rd = rd | 32'hFFFFFF00;
          end
          2'd1: begin
            rd = (word >> (8 * ln)) & 32'hFFFF;
            if (!u && rd >= 32'h8000) rd = rd | 32'hFFFF0000;
          end
          default: rd = word;
        endcase
      end
    end
  endtask

  task automatic run(input int s, input bit w, input logic [1:0] sz,
                     input bit u, input logic [11:0] a,
                     input logic [31:0] wd, input string tag,
                     output logic [31:0] rd);
    logic [31:0] erd;
    logic er, eer;
    int lat;
    xact(s, w, sz, u, a, wd, rd, er, lat);
    model(s, w, sz, u, a, wd, erd, eer);
    chk({tag, "/rdata"}, rd, erd);
    chk({tag, "/err"}, {31'h0, er}, {31'h0, eer});
    chk({tag, "/lat"}, lat, (s == 0) ? 3 : 1);
  endtask

  task automatic chk_reset(input int s, input string tag);
    chk({tag, "/ReqReady"}, {31'h0, rqr(s)}, 32'h1);
    chk({tag, "/RespValid"}, {31'h0, rv(s)}, 32'h0);
    chk({tag, "/RData"}, rdo(s), 32'h0);
    chk({tag, "/RespErr"}, {31'h0, rer(s)}, 32'h0);
    chk({tag, "/Busy"}, {31'h0, bsy(s)}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int got;
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);

    #12;
    chk_reset(0, "por_l2");
    chk_reset(1, "por_l0");
    @(negedge clk);
    rst = 1'b1;

    // Reset during WAIT of a store must not commit it.
    run(0, 1, 2'd2, 0, 12'h010, 32'h0BADF00D, "pre_store", rd);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF);
    @(posedge clk);
    #1 set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    @(negedge clk);
    chk("wait/Busy", {31'h0, bsy(0)}, 32'h1);
    rst = 1'b0;
    #1 chk_reset(0, "mid_rst");
    @(posedge clk);
    #1 chk_reset(0, "mid_rst_edge");
    @(negedge clk);
    rst = 1'b1;
    run(0, 0, 2'd2, 0, 12'h010, 32'h0, "post_rst_ld", rd);
    chk("post_rst_val", rd, 32'h0BADF00D);

    run(0, 1, 2'd2, 0, 12'h020, 32'h12345678, "st_w", rd);
    run(0, 0, 2'd2, 0, 12'h020, 32'h0, "ld_w", rd);
    chk("ld_w_val", rd, 32'h12345678);

    run(0, 1, 2'd2, 0, 12'h020, 32'h80FF7F01, "st_w2", rd);
    run(0, 0, 2'd0, 0, 12'h022, 32'h0, "lb_22", rd);
    chk("lb_22_val", rd, 32'hFFFFFFFF);
    run(0, 0, 2'd0, 1, 12'h022, 32'h0, "lbu_22", rd);
    chk("lbu_22_val", rd, 32'h000000FF);
    run(0, 0, 2'd1, 0, 12'h022, 32'h0, "lh_22", rd);
    chk("lh_22_val", rd, 32'hFFFF80FF);
    run(0, 0, 2'd0, 0, 12'h020, 32'h0, "lb_20", rd);
    chk("lb_20_val", rd, 32'h00000001);

    run(0, 1, 2'd2, 0, 12'h030, 32'h11223344, "st_w3", rd);
    run(0, 1, 2'd0, 0, 12'h031, 32'h000000AA, "sb_31", rd);
    run(0, 0, 2'd2, 0, 12'h030, 32'h0, "ld_w3", rd);
    chk("partial_val", rd, 32'h1122AA44);

    run(0, 0, 2'd2, 0, 12'h022, 32'h0, "err_lw", rd);
    run(0, 1, 2'd1, 0, 12'h023, 32'h0000BEEF, "err_sh", rd);
    run(0, 1, 2'd3, 0, 12'h020, 32'hFFFFFFFF, "err_sz", rd);
    run(0, 0, 2'd2, 0, 12'h020, 32'h0, "err_after", rd);
    chk("err_ram_val", rd, 32'h80FF7F01);

    // Hold the response for five cycles.
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
    @(posedge clk);
    #1 set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv(0) === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("bp/resp_seen", got, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp/RespValid", {31'h0, rv(0)}, 32'h1);
      chk("bp/RData", rdo(0), 32'h80FF7F01);
      chk("bp/ReqReady", {31'h0, rqr(0)}, 32'h0);
      chk("bp/Busy", {31'h0, bsy(0)}, 32'h1);
      @(negedge clk);
    end
    set_rr(0, 1'b1);
    @(posedge clk);
    #1 set_rr(0, 1'b0);
    @(negedge clk);
    chk("bp/ReqReady_after", {31'h0, rqr(0)}, 32'h1);
    chk("bp/Busy_after", {31'h0, bsy(0)}, 32'h0);
    chk("bp/RespValid_after", {31'h0, rv(0)}, 32'h0);

    run(1, 1, 2'd2, 0, 12'h040, 32'hCAFEF00D, "l0_st", rd);
    run(1, 0, 2'd2, 0, 12'h040, 32'h0, "l0_ld", rd);
    chk("l0_ld_val", rd, 32'hCAFEF00D);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++)
        run(s, 1, 2'd2, 0, 12'(32'h100 + 4 * i), $urandom, "rnd_init", rd);
      for (int i = 0; i < 60; i++)
        run(s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 12'(32'h100 + $urandom_range(0, 63)),
            $urandom, "rnd", rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
